// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   imem_req   : request strobe, driven by the fetch stage
//   imem_addr  : request address, driven by the fetch stage
//   imem_ready : memory returns data this cycle
//   imem_data  : returned instruction word
// master modport = fetch stage, slave modport = instruction memory.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 20
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage, writer side of the IF/ID register.
// Holds the PC, requests instructions over the imem bus and presents each
// fetched word (plus its opcode and address) with a valid flag. Handles
// decode stall (hold the presented word) and branch redirect (squash).
//
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous, active-low
//   stall          : IF/ID cannot accept, hold presented instruction
//   branch_taken   : redirect PC to branch_target this cycle
//   branch_target  : redirect address
//   imem           : instruction-memory bus (master side)
//   instruction    : fetched instruction to IF/ID
//   opcode         : top 4 bits of instruction
//   valid          : instruction/opcode hold a real fetched instruction
//   pc_out         : address of the presented instruction
// Optional (FETCH_PERF_CNT_EN defined):
//   fetch_count    : accepted imem responses, saturating
//   squash_count   : branches that discarded a response or valid word, saturating
//
// state   | meaning
// S_FETCH | request outstanding at pc, accept response on imem_ready
// S_HOLD  | decode stalled, presented instruction frozen, no request
module fetch_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 20,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  fetch_unit_if.master           imem,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [3:0]             opcode,
  output logic                   valid,
  output logic [PC_WIDTH-1:0]    pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            fetch_count,
  output logic [15:0]            squash_count
`endif
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcout_q, pcout_d;
  logic                   resp;

  // A response only counts against a request actually on the bus; this
  // drops anything the memory returns in the cycle right after reset.
  assign resp = (state_q == S_FETCH) && req_q && imem.imem_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pcout_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pcout_d = pcout_q;
    if (branch_taken) begin
      // redirect wins over stall and over any response this cycle
      state_d = S_FETCH;
      pc_d    = branch_target;
      req_d   = 1'b1;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (resp) begin
            instr_d = imem.imem_data;
            pcout_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_WIDTH'(1);
            if (stall) begin
              state_d = S_HOLD;
              req_d   = 1'b0;
            end else begin
              req_d   = 1'b1;
            end
          end else begin
            valid_d = 1'b0;
            req_d   = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_d = S_FETCH;
            req_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign opcode         = instr_q[INSTR_WIDTH-1 -: 4];
  assign valid          = valid_q;
  assign pc_out         = pcout_q;

`ifdef FETCH_PERF_CNT_EN
  logic take, squash;
  assign take   = resp && !branch_taken;
  assign squash = branch_taken && (resp || valid_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (take && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (squash && (squash_count != 16'hFFFF))
        squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule
